rst_seq_mgr: RTL and testbench

//  Parametrised reset sequencer; next generation of the two-domain bus/CPU reset manager.

---
 rtl/rst_seq_mgr_if.sv | 28 ++
 rtl/rst_seq_mgr.sv | 113 +++++++++++
 tb/tb_rst_seq_mgr.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_mgr_if.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_mgr_if
// Brief    : Request/status bundle between SoC reset control and rst_seq_mgr
// Revision : 1.0 - initial release
// ============================================================================
interface rst_seq_mgr_if #(
  parameter int NUM_DOM = 4
);
  logic               ext_req;
  logic               wdt_req;
  logic [NUM_DOM-1:0] sw_hold;
  logic               cause_clr;
  logic [NUM_DOM-1:0] dom_resetn;
  logic               seq_busy;
  logic [3:0]         rst_cause;

  modport master (
    output ext_req, wdt_req, sw_hold, cause_clr,
    input  dom_resetn, seq_busy, rst_cause
  );

  modport slave (
    input  ext_req, wdt_req, sw_hold, cause_clr,
    output dom_resetn, seq_busy, rst_cause
  );
endinterface
`default_nettype wire

// File: rtl/rst_seq_mgr.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_mgr
// Brief    : Releases NUM_DOM reset domains in order with programmable stretch,
//            handles hold/re-sequence requests and keeps a sticky reset cause.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_mgr #(
  parameter int NUM_DOM  = 4,
  parameter int HOLD_CYC = 8,
  parameter int STRETCH  = 5
) (
  input  wire logic   clk,
  input  wire logic   rst,
  rst_seq_mgr_if.slave bus
);

  localparam int c_PW   = $clog2(NUM_DOM + 1);
  localparam int c_CMAX = (HOLD_CYC > STRETCH) ? HOLD_CYC : STRETCH;
  localparam int c_CW   = (c_CMAX > 1) ? $clog2(c_CMAX) : 1;

  localparam logic [c_PW-1:0] c_PMAX      = c_PW'(NUM_DOM);
  localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(HOLD_CYC - 1);
  localparam logic [c_CW-1:0] c_STR_LAST  = c_CW'(STRETCH - 1);

  logic [c_PW-1:0]    r_p;
  logic [c_CW-1:0]    r_cnt;
  logic [NUM_DOM-1:0] r_dom_n;
  logic               r_busy;
  logic [3:0]         r_cause;

  logic [c_PW-1:0]    w_p_nxt;
  logic [c_CW-1:0]    w_cnt_nxt;
  logic [NUM_DOM-1:0] w_dom_nxt;
  logic [3:0]         w_cause_set;
  logic [3:0]         w_cause_nxt;
  logic               w_hit;
  logic [c_PW-1:0]    w_hit_idx;
  logic               w_stall;
  logic [c_CW-1:0]    w_lim_last;

  always_comb begin
    w_p_nxt     = r_p;
    w_cnt_nxt   = r_cnt;
    w_cause_set = 4'b0000;
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_stall     = 1'b0;
    w_dom_nxt   = '0;

    // Descending scan so the lowest held, already-released domain wins.
    for (int j = NUM_DOM - 1; j >= 0; j--) begin
      if (bus.sw_hold[j] && (j < int'(r_p))) begin
        w_hit     = 1'b1;
        w_hit_idx = c_PW'(j);
      end
      if (bus.sw_hold[j] && (j == int'(r_p))) begin
        w_stall = 1'b1;
      end
    end

    w_lim_last = (r_p == '0) ? c_HOLD_LAST : c_STR_LAST;

    if (bus.ext_req || bus.wdt_req) begin
      w_p_nxt        = '0;
      w_cnt_nxt      = '0;
      w_cause_set[1] = bus.ext_req;
      w_cause_set[2] = bus.wdt_req;
    end else if (w_hit) begin
      w_p_nxt        = w_hit_idx;
      w_cnt_nxt      = '0;
      w_cause_set[3] = 1'b1;
    end else if (r_p == c_PMAX) begin
      w_cnt_nxt = '0;
    end else if (w_stall) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == w_lim_last) begin
      w_p_nxt   = r_p + 1'b1;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    for (int j = 0; j < NUM_DOM; j++) begin
      w_dom_nxt[j] = (int'(w_p_nxt) > j);
    end

    // A cause set in the same cycle as cause_clr survives the clear.
    w_cause_nxt = (bus.cause_clr ? 4'b0000 : r_cause) | w_cause_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= '0;
      r_cnt   <= '0;
      r_dom_n <= '0;
      r_busy  <= 1'b1;
      r_cause <= 4'b0001;
    end else begin
      r_p     <= w_p_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dom_n <= w_dom_nxt;
      r_busy  <= (w_p_nxt != c_PMAX);
      r_cause <= w_cause_nxt;
    end
  end

  assign bus.dom_resetn = r_dom_n;
  assign bus.seq_busy   = r_busy;
  assign bus.rst_cause  = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_mgr
// Brief    : Vector table, hand sequences and random stimulus for rst_seq_mgr
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_mgr;
  localparam int N = 4;
  localparam int H = 8;
  localparam int S = 5;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rst_seq_mgr_if #(.NUM_DOM(N)) bus ();
  rst_seq_mgr_if #(.NUM_DOM(N)) bus2 ();

  rst_seq_mgr #(.NUM_DOM(N), .HOLD_CYC(H), .STRETCH(S)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  rst_seq_mgr #(.NUM_DOM(N), .HOLD_CYC(1), .STRETCH(1)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  // Reference model: stage index plus edges spent in the current stage.
  int         m_stage;
  int         m_age;
  logic [3:0] m_cause;

  function automatic logic [N-1:0] therm(int p);
    logic [N-1:0] v = '0;
    for (int j = 0; j < N; j++) if (j < p) v[j] = 1'b1;
    return v;
  endfunction

  function automatic void model_edge(logic r, logic ext, logic wdt,
                                     logic [N-1:0] hold, logic clr);
    int low = -1;
    logic [3:0] set = 4'b0000;
    if (r) begin
      m_stage = 0; m_age = 0; m_cause = 4'b0001;
      return;
    end
    for (int j = 0; j < N; j++) if (hold[j] && j < m_stage && low < 0) low = j;
    if (ext || wdt) begin
      m_stage = 0; m_age = 0; set = {1'b0, wdt, ext, 1'b0};
    end else if (low >= 0) begin
      m_stage = low; m_age = 0; set = 4'b1000;
    end else if (m_stage == N || hold[m_stage]) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == ((m_stage == 0) ? H : S)) begin
        m_stage++; m_age = 0;
      end
    end
    m_cause = (clr ? 4'b0000 : m_cause) | set;
  endfunction

  task automatic check(string name, logic [N-1:0] dom_a, logic busy_a, logic [3:0] cause_a,
                       logic [N-1:0] dom_e, logic busy_e, logic [3:0] cause_e);
    n_cmp++;
    if (dom_a !== dom_e || busy_a !== busy_e || cause_a !== cause_e) begin
      n_err++;
      $display("FAIL %s: got dom=%b busy=%b cause=%b, expected dom=%b busy=%b cause=%b",
               name, dom_a, busy_a, cause_a, dom_e, busy_e, cause_e);
    end
  endtask

  task automatic tick(logic r, logic ext, logic wdt, logic [N-1:0] hold, logic clr);
    rst = r; bus.ext_req = ext; bus.wdt_req = wdt; bus.sw_hold = hold; bus.cause_clr = clr;
    @(posedge clk);
    model_edge(r, ext, wdt, hold, clr);
    #1;
    check("model", bus.dom_resetn, bus.seq_busy, bus.rst_cause,
          therm(m_stage), (m_stage != N), m_cause);
  endtask

  typedef struct {
    string        name;
    logic         r;
    logic         ext;
    logic         wdt;
    logic [N-1:0] hold;
    logic         clr;
    int           cycles;
    logic [N-1:0] e_dom;
    logic         e_busy;
    logic [3:0]   e_cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic r, logic ext, logic wdt, logic [N-1:0] hold,
                              logic clr, int cyc, logic [N-1:0] d, logic b, logic [3:0] c);
    vec_t v;
    v.name = nm; v.r = r; v.ext = ext; v.wdt = wdt; v.hold = hold; v.clr = clr;
    v.cycles = cyc; v.e_dom = d; v.e_busy = b; v.e_cause = c;
    return v;
  endfunction

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ext_req = 0; bus.wdt_req = 0; bus.sw_hold = '0; bus.cause_clr = 0;
    bus2.ext_req = 0; bus2.wdt_req = 0; bus2.sw_hold = '0; bus2.cause_clr = 0;

    //            name            r  e  w  hold     c  n   dom      b  cause
    vecs.push_back(mk("reset",     1, 0, 0, 4'b0000, 0, 2,  4'b0000, 1, 4'b0001));
    vecs.push_back(mk("t1_e7",     0, 0, 0, 4'b0000, 0, 7,  4'b0000, 1, 4'b0001));
    vecs.push_back(mk("t1_e8",     0, 0, 0, 4'b0000, 0, 1,  4'b0001, 1, 4'b0001));
    vecs.push_back(mk("t1_e12",    0, 0, 0, 4'b0000, 0, 4,  4'b0001, 1, 4'b0001));
    vecs.push_back(mk("t1_e13",    0, 0, 0, 4'b0000, 0, 1,  4'b0011, 1, 4'b0001));
    vecs.push_back(mk("t1_e18",    0, 0, 0, 4'b0000, 0, 5,  4'b0111, 1, 4'b0001));
    vecs.push_back(mk("t1_e23",    0, 0, 0, 4'b0000, 0, 5,  4'b1111, 0, 4'b0001));
    vecs.push_back(mk("t2_drop",   0, 0, 0, 4'b0010, 0, 1,  4'b0001, 1, 4'b1001));
    vecs.push_back(mk("t2_stall",  0, 0, 0, 4'b0010, 0, 2,  4'b0001, 1, 4'b1001));
    vecs.push_back(mk("t2_p4",     0, 0, 0, 4'b0000, 0, 4,  4'b0001, 1, 4'b1001));
    vecs.push_back(mk("t2_p5",     0, 0, 0, 4'b0000, 0, 1,  4'b0011, 1, 4'b1001));
    vecs.push_back(mk("t2_p10",    0, 0, 0, 4'b0000, 0, 5,  4'b0111, 1, 4'b1001));
    vecs.push_back(mk("t2_p15",    0, 0, 0, 4'b0000, 0, 5,  4'b1111, 0, 4'b1001));
    vecs.push_back(mk("t4_extclr", 0, 1, 0, 4'b0000, 1, 1,  4'b0000, 1, 4'b0010));
    vecs.push_back(mk("t4_after",  0, 0, 0, 4'b0000, 0, 1,  4'b0000, 1, 4'b0010));
    vecs.push_back(mk("t4_clr",    0, 0, 0, 4'b0000, 1, 1,  4'b0000, 1, 4'b0000));
    vecs.push_back(mk("t4_rel",    0, 0, 0, 4'b0000, 0, 6,  4'b0001, 1, 4'b0000));
    vecs.push_back(mk("t3_rst",    1, 0, 0, 4'b0000, 0, 1,  4'b0000, 1, 4'b0001));
    vecs.push_back(mk("t3_e15",    0, 0, 0, 4'b0000, 0, 15, 4'b0011, 1, 4'b0001));
    vecs.push_back(mk("t3_wdt",    0, 0, 1, 4'b0000, 0, 1,  4'b0000, 1, 4'b0101));
    vecs.push_back(mk("t3_w7",     0, 0, 0, 4'b0000, 0, 7,  4'b0000, 1, 4'b0101));
    vecs.push_back(mk("t3_w8",     0, 0, 0, 4'b0000, 0, 1,  4'b0001, 1, 4'b0101));
    vecs.push_back(mk("t3_run",    0, 0, 0, 4'b0000, 0, 15, 4'b1111, 0, 4'b0101));
    vecs.push_back(mk("t5_rst",    1, 0, 0, 4'b1000, 0, 1,  4'b0000, 1, 4'b0001));
    vecs.push_back(mk("t5_stall",  0, 0, 0, 4'b1000, 0, 30, 4'b0111, 1, 4'b0001));
    vecs.push_back(mk("t5_rel4",   0, 0, 0, 4'b0000, 0, 4,  4'b0111, 1, 4'b0001));
    vecs.push_back(mk("t5_rel5",   0, 0, 0, 4'b0000, 0, 1,  4'b1111, 0, 4'b0001));
    vecs.push_back(mk("t6_wdt",    0, 0, 1, 4'b0000, 0, 1,  4'b0000, 1, 4'b0101));
    vecs.push_back(mk("t6_stall",  0, 0, 0, 4'b1000, 0, 25, 4'b0111, 1, 4'b0101));
    vecs.push_back(mk("t6_rst",    1, 0, 0, 4'b1000, 0, 1,  4'b0000, 1, 4'b0001));

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].cycles; k++)
        tick(vecs[i].r, vecs[i].ext, vecs[i].wdt, vecs[i].hold, vecs[i].clr);
      check(vecs[i].name, bus.dom_resetn, bus.seq_busy, bus.rst_cause,
            vecs[i].e_dom, vecs[i].e_busy, vecs[i].e_cause);
    end

    // Held ext_req pins the sequencer at stage 0 until it drops.
    tick(0, 0, 0, 4'b0000, 1);
    for (int k = 0; k < 20; k++) tick(0, 1, 0, 4'b0000, 0);
    check("ext_level", bus.dom_resetn, bus.seq_busy, bus.rst_cause, 4'b0000, 1'b1, 4'b0010);
    for (int k = 0; k < H; k++) tick(0, 0, 0, 4'b0000, 0);
    check("ext_drop", bus.dom_resetn, bus.seq_busy, bus.rst_cause, 4'b0001, 1'b1, 4'b0010);

    // Hold on domain 0 from RUN, then release: domain 0 returns after HOLD_CYC.
    for (int k = 0; k < 3 * S; k++) tick(0, 0, 0, 4'b0000, 0);
    tick(0, 0, 0, 4'b0001, 0);
    check("hold0_drop", bus.dom_resetn, bus.seq_busy, bus.rst_cause, 4'b0000, 1'b1, 4'b1010);
    for (int k = 0; k < H - 1; k++) tick(0, 0, 0, 4'b0000, 0);
    check("hold0_h-1", bus.dom_resetn, bus.seq_busy, bus.rst_cause, 4'b0000, 1'b1, 4'b1010);
    tick(0, 0, 0, 4'b0000, 0);
    check("hold0_h", bus.dom_resetn, bus.seq_busy, bus.rst_cause, 4'b0001, 1'b1, 4'b1010);

    // Random stimulus against the reference model.
    tick(1, 0, 0, 4'b0000, 0);
    for (int k = 0; k < 3000; k++) begin
      logic         r, e, w, c;
      logic [N-1:0] h;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 79) == 0);
      c = ($urandom_range(0, 29) == 0);
      h = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      tick(r, e, w, h, c);
    end

    // Minimum-length parameters on the second instance.
    rst2 = 1'b1;
    @(posedge clk); #1;
    check("min_reset", bus2.dom_resetn, bus2.seq_busy, bus2.rst_cause, 4'b0000, 1'b1, 4'b0001);
    rst2 = 1'b0;
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      check($sformatf("min_edge%0d", k), bus2.dom_resetn, bus2.seq_busy, bus2.rst_cause,
            therm(k), (k != N), 4'b0001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
